mig_app_arbiter: RTL and testbench

MIG_APP_ARBITER -- requirements
Module: mig_app_arbiter

---
 rtl/mig_app_arbiter.sv | 113 +++++++++++
 tb/tb_mig_app_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mig_app_arbiter.sv
// mig_app_arbiter: alternating-priority write/read arbiter feeding a MIG UI port,
// with read-credit limiting, registered outputs and one-cycle read-return pipeline.
module mig_app_arbiter #(
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic         ui_clk,
  input  logic         ui_clk_sync_rst,
  input  logic         init_calib_complete,
  input  logic         app_rdy,
  input  logic         app_wdf_rdy,
  input  logic [255:0] app_rd_data,
  input  logic         app_rd_data_valid,
  output logic         app_en,
  output logic [2:0]   app_cmd,
  output logic [28:0]  app_addr,
  output logic [255:0] app_wdf_data,
  output logic         app_wdf_wren,
  output logic         app_wdf_end,
  input  logic         wr_req,
  input  logic [28:0]  wr_addr,
  input  logic [255:0] wr_data,
  output logic         wr_gnt,
  input  logic         rd_req,
  input  logic [28:0]  rd_addr,
  output logic         rd_gnt,
  output logic [255:0] rd_data,
  output logic         rd_data_valid,
  output logic         busy,
  output logic         err
);
  localparam logic [4:0] MAX = 5'(MAX_OUTSTANDING);
  typedef enum logic [1:0] {IDLE, WR, RD} state_t;
  state_t state, state_n;
  logic [4:0] cnt, cnt_n;
  logic pref_wr, pref_wr_n;
  logic en_n, wren_n, wgnt_n, rgnt_n, rd_ok, go_rd;
  logic [2:0] cmd_n;
  logic [28:0] addr_n;
  logic [255:0] wdata_n;
  always_comb begin
    state_n = state;
    en_n = app_en;
    cmd_n = app_cmd;
    addr_n = app_addr;
    wdata_n = app_wdf_data;
    wren_n = app_wdf_wren;
    wgnt_n = 1'b0;
    rgnt_n = 1'b0;
    pref_wr_n = pref_wr;
    rd_ok = rd_req && (cnt < MAX);
    go_rd = rd_ok && (!wr_req || !pref_wr);
    unique case (state)
      IDLE: if (init_calib_complete && (wr_req || rd_ok)) begin
        state_n = go_rd ? RD : WR;
        en_n = 1'b1;
        cmd_n = go_rd ? 3'b001 : 3'b000;
        addr_n = (go_rd ? rd_addr : wr_addr) & ~29'h7;
        wdata_n = go_rd ? app_wdf_data : wr_data;
        wren_n = !go_rd;
        wgnt_n = !go_rd;
        rgnt_n = go_rd;
        pref_wr_n = go_rd;
      end
      WR: begin
        en_n = app_en && !app_rdy;
        wren_n = app_wdf_wren && !app_wdf_rdy;
        if (!en_n && !wren_n) state_n = IDLE;
      end
      RD: if (app_rdy) begin
        en_n = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // a return with nothing outstanding is an error and must not underflow
    cnt_n = cnt + {4'b0, state == RD && app_rdy} - {4'b0, app_rd_data_valid && cnt != 5'd0};
  end
  always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
    if (ui_clk_sync_rst) begin
      state <= IDLE;
      cnt <= '0;
      pref_wr <= 1'b1;
      app_en <= 1'b0;
      app_cmd <= '0;
      app_addr <= '0;
      app_wdf_data <= '0;
      app_wdf_wren <= 1'b0;
      app_wdf_end <= 1'b0;
      wr_gnt <= 1'b0;
      rd_gnt <= 1'b0;
      rd_data <= '0;
      rd_data_valid <= 1'b0;
      busy <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      pref_wr <= pref_wr_n;
      app_en <= en_n;
      app_cmd <= cmd_n;
      app_addr <= addr_n;
      app_wdf_data <= wdata_n;
      app_wdf_wren <= wren_n;
      app_wdf_end <= wren_n;
      wr_gnt <= wgnt_n;
      rd_gnt <= rgnt_n;
      rd_data_valid <= app_rd_data_valid;
      if (app_rd_data_valid) rd_data <= app_rd_data;
      busy <= (state_n != IDLE) || (cnt_n != 5'd0);
      err <= err || (app_rd_data_valid && cnt == 5'd0);
    end
  end
endmodule

// File: tb/tb_mig_app_arbiter.sv
// tb_mig_app_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model of the arbiter and an in-order MIG read queue.
module tb_mig_app_arbiter;
  localparam int MAXO = 2;
  logic clk = 1'b0, rst = 1'b0;
  logic init_calib_complete, app_rdy, app_wdf_rdy, app_rd_data_valid;
  logic [255:0] app_rd_data;
  logic app_en, app_wdf_wren, app_wdf_end, wr_gnt, rd_gnt, rd_data_valid, busy, err;
  logic [2:0] app_cmd;
  logic [28:0] app_addr, wr_addr, rd_addr;
  logic [255:0] app_wdf_data, wr_data, rd_data;
  logic wr_req, rd_req;
  always #5 clk = ~clk;
  mig_app_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
    .ui_clk(clk), .ui_clk_sync_rst(rst), .init_calib_complete(init_calib_complete),
    .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
    .app_rd_data_valid(app_rd_data_valid), .app_en(app_en), .app_cmd(app_cmd),
    .app_addr(app_addr), .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren),
    .app_wdf_end(app_wdf_end), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_gnt(wr_gnt), .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid), .busy(busy), .err(err)
  );
  int n_chk = 0, n_fail = 0;
  bit m_act, m_rd, m_cp, m_dp, m_pref_wr, m_err;
  int m_cnt;
  logic [28:0] rq[$];
  logic e_wgnt, e_rgnt, e_en, e_wren, e_rdv, e_busy, e_err;
  logic [2:0] e_cmd;
  logic [28:0] e_addr;
  logic [255:0] e_wdata, e_rdata;
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic check_all();
    chk("wr_gnt", wr_gnt, e_wgnt);
    chk("rd_gnt", rd_gnt, e_rgnt);
    chk("app_en", app_en, e_en);
    chk("app_wdf_wren", app_wdf_wren, e_wren);
    chk("app_wdf_end", app_wdf_end, e_wren);
    chk("app_cmd", app_cmd, e_cmd);
    chk("app_addr", app_addr, e_addr);
    chk("app_wdf_data", app_wdf_data, e_wdata);
    chk("rd_data_valid", rd_data_valid, e_rdv);
    chk("rd_data", rd_data, e_rdata);
    chk("busy", busy, e_busy);
    chk("err", err, e_err);
  endtask
  task automatic reset_model();
    {m_act, m_rd, m_cp, m_dp, m_err} = '0;
    m_pref_wr = 1'b1;
    m_cnt = 0;
    rq.delete();
    {e_wgnt, e_rgnt, e_en, e_wren, e_rdv, e_busy, e_err} = '0;
    e_cmd = '0;
    e_addr = '0;
    e_wdata = '0;
    e_rdata = '0;
  endtask
  // Predicts the outputs of the next cycle from the model state and the inputs at the coming edge.
  task automatic predict();
    int c0 = m_cnt;
    bit w, r, pick_rd;
    e_wgnt = 1'b0;
    e_rgnt = 1'b0;
    if (m_act) begin
      if (!m_rd) begin
        if (app_rdy) m_cp = 1'b0;
        if (app_wdf_rdy) m_dp = 1'b0;
        m_act = m_cp || m_dp;
      end else if (app_rdy) begin
        m_cnt++;
        rq.push_back(e_addr);
        m_cp = 1'b0;
        m_act = 1'b0;
      end
    end else if (init_calib_complete) begin
      w = wr_req;
      r = rd_req && c0 < MAXO;
      if (w || r) begin
        pick_rd = r && (!w || !m_pref_wr);
        m_act = 1'b1;
        m_rd = pick_rd;
        m_cp = 1'b1;
        m_dp = !pick_rd;
        m_pref_wr = pick_rd;
        e_cmd = pick_rd ? 3'b001 : 3'b000;
        e_addr = (pick_rd ? rd_addr : wr_addr) & 29'h1FFF_FFF8;
        if (!pick_rd) e_wdata = wr_data;
        e_wgnt = !pick_rd;
        e_rgnt = pick_rd;
      end
    end
    if (app_rd_data_valid) begin
      if (c0 == 0) m_err = 1'b1;
      else m_cnt--;
      if (rq.size() > 0) void'(rq.pop_front());
      e_rdata = app_rd_data;
    end
    e_rdv = app_rd_data_valid;
    e_en = m_cp;
    e_wren = m_dp;
    e_busy = m_act || m_cnt != 0;
    e_err = m_err;
  endtask
  task automatic tick();
    predict();
    @(posedge clk);
    #1;
    check_all();
  endtask
  task automatic do_reset();
    wr_req = 1'b0;
    rd_req = 1'b0;
    app_rd_data_valid = 1'b0;
    rst = 1'b1;
    reset_model();
    #1;
    check_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic ret(input int pct);
    app_rd_data = {8{$urandom}};
    app_rd_data_valid = rq.size() > 0 && $urandom_range(0, 99) < pct;
    if (app_rd_data_valid) app_rd_data = {227'b0, rq[0]} ^ {32{8'h5A}};
  endtask
  initial begin
    int nw, ng;
    init_calib_complete = 1'b0;
    app_rdy = 1'b0;
    app_wdf_rdy = 1'b0;
    app_rd_data = '0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    do_reset();
    wr_req = 1'b1;
    wr_addr = 29'h1234567;
    wr_data = 256'hBEEF;
    app_rdy = 1'b1;
    app_wdf_rdy = 1'b1;
    repeat (20) begin
      tick();
      chk("gate_gnt", wr_gnt, 0);
      chk("gate_en", app_en, 0);
    end
    init_calib_complete = 1'b1;
    tick();
    chk("calib_gnt", wr_gnt, 1);
    wr_req = 1'b0;
    repeat (2) tick();
    wr_req = 1'b1;
    wr_addr = 29'hF;
    wr_data = 256'hA5;
    app_wdf_rdy = 1'b0;
    tick();
    chk("wr_addr", app_addr, 29'h8);
    wr_req = 1'b0;
    nw = 0;
    for (int i = 0; i < 8; i++) begin
      if (app_wdf_wren) nw++;
      if (i == 3) app_wdf_rdy = 1'b1;
      tick();
    end
    chk("wren_cycles", nw, 4);
    chk("wr_idle", busy, 0);
    do_reset();
    wr_req = 1'b1;
    rd_req = 1'b1;
    ng = 0;
    for (int i = 0; i < 100 && ng < 8; i++) begin
      ret(100);
      tick();
      if (wr_gnt || rd_gnt) begin
        chk("fair_seq", rd_gnt, 256'(ng % 2));
        ng++;
        wr_addr = 29'($urandom);
        rd_addr = 29'($urandom);
        wr_data = {8{$urandom}};
      end
    end
    chk("fair_count", ng, 8);
    do_reset();
    rd_req = 1'b1;
    ng = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rd_gnt) ng++;
    end
    chk("credit_block", ng, 2);
    chk("credit_busy", busy, 1);
    app_rd_data_valid = 1'b1;
    tick();
    app_rd_data_valid = 1'b0;
    for (int i = 0; i < 10 && ng < 3; i++) begin
      tick();
      if (rd_gnt) begin
        ng++;
        rd_req = 1'b0;
      end
    end
    chk("credit_release", ng, 3);
    rd_req = 1'b0;
    repeat (2) tick();
    app_rd_data_valid = 1'b1;
    app_rd_data = 256'h1234;
    tick();
    chk("ret_valid", rd_data_valid, 1);
    chk("ret_data", rd_data, 256'h1234);
    app_rd_data_valid = 1'b0;
    app_rd_data = 256'hDEAD;
    tick();
    chk("ret_hold", rd_data, 256'h1234);
    app_rd_data_valid = 1'b1;
    tick();
    app_rd_data_valid = 1'b0;
    tick();
    chk("no_err", err, 0);
    chk("drained", busy, 0);
    app_rd_data_valid = 1'b1;
    tick();
    app_rd_data_valid = 1'b0;
    chk("err_set", err, 1);
    repeat (3) tick();
    chk("err_sticky", err, 1);
    chk("err_cnt_zero", busy, 0);
    do_reset();
    wr_req = 1'b1;
    app_rdy = 1'b0;
    app_wdf_rdy = 1'b0;
    tick();
    wr_req = 1'b0;
    tick();
    chk("mid_wr_en", app_en, 1);
    do_reset();
    chk("rst_wren", app_wdf_wren, 0);
    repeat (3) tick();
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if (e_wgnt) wr_req = 1'b0;
      if (e_rgnt) rd_req = 1'b0;
      if (!wr_req && $urandom_range(0, 3) == 0) begin
        wr_req = 1'b1;
        wr_addr = 29'($urandom);
        wr_data = {8{$urandom}};
      end
      if (!rd_req && $urandom_range(0, 3) == 0) begin
        rd_req = 1'b1;
        rd_addr = 29'($urandom);
      end
      app_rdy = $urandom_range(0, 2) != 0;
      app_wdf_rdy = $urandom_range(0, 2) != 0;
      init_calib_complete = $urandom_range(0, 15) != 0;
      ret(30);
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
